// File: rtl/demux1to4_buf.sv
// demux1to4_buf: 1-to-4 valid/ready demultiplexer with a 2-entry FIFO per output channel
module demux1to4_buf #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [3:0]          ch_full,
    output logic [7:0]          drop_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    assign in_ready = ~ch_full[in_sel];

    always_ff @(posedge clk or posedge rst)
        if (rst)
            drop_cnt <= '0;
        else if (in_valid && !in_ready && drop_cnt != 8'hff)
            drop_cnt <= drop_cnt + 8'd1;

    genvar i;
    for (i = 0; i < 4; i++) begin : g_ch
        state_t state, state_nx;
        logic [DATA_W-1:0] head, tail;
        logic push, pop;
        assign push = in_valid && in_ready && in_sel == 2'(i);
        assign pop = out_valid[i] && out_ready[i];
        always_comb begin
            state_nx = state;
            state_nx = state == EMPTY ? (push ? ONE : EMPTY)
                     : state == ONE ? (push && !pop ? FULL : !push && pop ? EMPTY : ONE)
                     : (pop ? ONE : FULL);
        end
        // head is the slot exposed to the consumer; tail only holds the second word
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                state <= EMPTY;
                head  <= '0;
                tail  <= '0;
            end else begin
                state <= state_nx;
                if (push && (state == EMPTY || pop))
                    head <= in_data;
                else if (state == FULL && pop)
                    head <= tail;
                if (push && state == ONE && !pop)
                    tail <= in_data;
            end
        assign out_valid[i] = state != EMPTY;
        assign ch_full[i] = state == FULL;
        assign out_data[i*DATA_W +: DATA_W] = head;
    end
endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf: directed scenarios for the 1-to-4 buffered demultiplexer
module tb_demux1to4_buf;
    logic        clk = 0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  ch_full;
    logic [7:0]  drop_cnt;
    int checks = 0;
    int errors = 0;

    demux1to4_buf #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .ch_full(ch_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [1:0] s, input logic [7:0] d);
        in_sel = s;
        in_data = d;
        in_valid = 1;
    endtask

    task automatic test_reset;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid got %b exp 0000", out_valid); end
        checks++; if (ch_full !== 4'b0000) begin errors++; $display("FAIL rst_full got %b exp 0000", ch_full); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
        @(negedge clk); push(2, 8'h77);
        @(negedge clk); push(2, 8'h78);
        @(negedge clk); #1;
        checks++; if (ch_full !== 4'b0100) begin errors++; $display("FAIL pre_full got %b exp 0100", ch_full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pre_ready got %b exp 0", in_ready); end
        @(negedge clk);
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL pre_drop got %0d exp 1", drop_cnt); end
        in_valid = 0;
        #2 rst = 1;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL async_valid got %b exp 0000", out_valid); end
        checks++; if (ch_full !== 4'b0000) begin errors++; $display("FAIL async_full got %b exp 0000", ch_full); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL async_drop got %0d exp 0", drop_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b exp 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL async_data got %h exp 0", out_data); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_routing;
        out_ready = 4'b1111;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 4'(1 << (i - 1))) begin errors++; $display("FAIL route_valid%0d got %b", i - 1, out_valid); end
                checks++; if (out_data[(i-1)*8 +: 8] !== 8'hA0 + 8'(i - 1)) begin errors++; $display("FAIL route_data%0d got %h exp %h", i - 1, out_data[(i-1)*8 +: 8], 8'hA0 + 8'(i - 1)); end
            end
            if (i < 4) push(2'(i), 8'hA0 + 8'(i));
            else in_valid = 0;
        end
        @(negedge clk);
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL route_end got %b exp 0000", out_valid); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL route_drop got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_fill;
        out_ready = 4'b0000;
        @(negedge clk); push(1, 8'h11);
        @(negedge clk);
        checks++; if (out_data[15:8] !== 8'h11 || out_valid !== 4'b0010) begin errors++; $display("FAIL fill_one got %h/%b exp 11/0010", out_data[15:8], out_valid); end
        checks++; if (ch_full !== 4'b0000) begin errors++; $display("FAIL fill_notfull got %b exp 0000", ch_full); end
        push(1, 8'h22);
        @(negedge clk); push(1, 8'h33); #1;
        checks++; if (ch_full !== 4'b0010) begin errors++; $display("FAIL fill_full got %b exp 0010", ch_full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", in_ready); end
        @(negedge clk);
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL fill_drop1 got %0d exp 1", drop_cnt); end
        @(negedge clk);
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL fill_drop2 got %0d exp 2", drop_cnt); end
        checks++; if (out_data[15:8] !== 8'h11) begin errors++; $display("FAIL fill_hold got %h exp 11", out_data[15:8]); end
        in_valid = 0;
    endtask

    task automatic test_isolation;
        push(3, 8'h55); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL iso_ready got %b exp 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL iso_valid got %b exp 1010", out_valid); end
        checks++; if (out_data[31:24] !== 8'h55) begin errors++; $display("FAIL iso_data got %h exp 55", out_data[31:24]); end
        in_valid = 0;
    endtask

    task automatic test_drain;
        push(1, 8'h33);
        out_ready = 4'b0010;
        @(negedge clk);
        checks++; if (out_data[15:8] !== 8'h22) begin errors++; $display("FAIL drain_22 got %h exp 22", out_data[15:8]); end
        checks++; if (ch_full !== 4'b0000) begin errors++; $display("FAIL drain_full got %b exp 0000", ch_full); end
        @(negedge clk);
        checks++; if (out_data[15:8] !== 8'h33 || out_valid !== 4'b1010) begin errors++; $display("FAIL drain_33 got %h/%b exp 33/1010", out_data[15:8], out_valid); end
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL drain_end got %b exp 1000", out_valid); end
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL drain_drop got %0d exp 3", drop_cnt); end
        out_ready = 4'b1000;
        @(negedge clk);
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL drain_ch3 got %b exp 0000", out_valid); end
        out_ready = 4'b0000;
    endtask

    task automatic test_simultaneous;
        push(0, 8'h10);
        @(negedge clk);
        checks++; if (out_data[7:0] !== 8'h10) begin errors++; $display("FAIL sim_head got %h exp 10", out_data[7:0]); end
        push(0, 8'h20);
        out_ready = 4'b0001;
        @(negedge clk);
        checks++; if (out_data[7:0] !== 8'h20 || out_valid !== 4'b0001) begin errors++; $display("FAIL sim_new got %h/%b exp 20/0001", out_data[7:0], out_valid); end
        checks++; if (ch_full !== 4'b0000) begin errors++; $display("FAIL sim_full got %b exp 0000", ch_full); end
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL sim_empty got %b exp 0000", out_valid); end
        out_ready = 4'b0000;
    endtask

    task automatic test_saturation;
        push(2, 8'h01);
        @(negedge clk); push(2, 8'h02);
        @(negedge clk); push(2, 8'h03);
        repeat (251) @(negedge clk);
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", drop_cnt); end
        repeat (49) @(negedge clk);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", drop_cnt); end
        checks++; if (out_data[23:16] !== 8'h01 || ch_full !== 4'b0100) begin errors++; $display("FAIL sat_hold got %h/%b exp 01/0100", out_data[23:16], ch_full); end
        in_valid = 0;
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        in_sel = 0;
        in_data = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        test_reset;
        test_routing;
        test_fill;
        test_isolation;
        test_drain;
        test_simultaneous;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux1to4_buf.md
Name: demux1to4_buf

Overview:
- 1-to-4 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the 4-to-1 mux.
- One input stream carries a 2-bit select. Each accepted word is routed to one of four output channels.
- Each output channel has a 2-entry FIFO, so a stalled consumer blocks only traffic addressed to its own channel.
- Sits between a single producer and four independent consumers.

Parameters:
- DATA_W, 8, width of one data word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  word to route.
- in_sel  input  2  destination channel, 0..3.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offered word this cycle.
- out_data  output  4*DATA_W  channel n data on bits [n*DATA_W +: DATA_W]; this is the head entry of FIFO n.
- out_valid  output  4  bit n set when FIFO n is non-empty.
- out_ready  input  4  bit n set when consumer n takes its head word.
- ch_full  output  4  bit n set when FIFO n holds 2 entries.
- drop_cnt  output  8  saturating count of cycles in which in_valid=1 and in_ready=0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All state clears immediately on rst=1, independent of clk.
- Reset values:
  - out_valid=4'b0000, ch_full=4'b0000, drop_cnt=0.
  - out_data=0 (FIFO storage cleared), all channel FSMs in EMPTY.
  - in_ready=1 during and after reset.
- Reset mid-operation: all buffered words are discarded and no output strobes. Operation resumes on the first rising edge after rst falls.
- Input transfer: occurs on a rising edge when in_valid=1 and in_ready=1.
- in_ready equals ~ch_full[in_sel].
  - It is combinational from in_sel and registered FIFO state only.
  - It never depends on out_ready, so there is no combinational ready path from the consumers.
- Output transfer on channel n: occurs on a rising edge when out_valid[n]=1 and out_ready[n]=1. This pops the head entry of FIFO n.
- Latency: a word accepted at edge k is visible on out_data/out_valid[n] after edge k, provided FIFO n was empty. Minimum latency is 1 cycle. Throughput is 1 word/cycle per channel.
- Ordering: per-channel FIFO order is preserved. There is no ordering relation between channels.
- Per-channel FSM, states EMPTY, ONE, FULL (push = input transfer with in_sel=n, pop = output transfer on n):
  - EMPTY: push -> ONE. Otherwise stay. Pop is impossible because out_valid=0.
  - ONE: push and no pop -> FULL. Pop and no push -> EMPTY. Push and pop together -> ONE, the new word becomes head on the next cycle. Neither -> ONE.
  - FULL: pop -> ONE, second entry becomes head. Push is impossible because in_ready=0. Neither -> FULL.
- Flags: out_valid[n] = (state != EMPTY); ch_full[n] = (state == FULL).
- Simultaneous events: a push to channel a and pops on any set of channels in the same cycle are all honoured.
- Stable outputs: out_data slice n holds its value while out_valid[n]=1 and out_ready[n]=0.
- Stall rule: when in_valid=1 and in_ready=0, the producer must hold in_data/in_sel. The block keeps no record of the stalled word.
- drop_cnt: increments by 1 on every edge where in_valid=1 and in_ready=0. It saturates at 255 and does not wrap. It is cleared only by rst.
- in_sel is ignored when in_valid=0. out_data slices of EMPTY channels are don't-care to consumers but must not be X after reset.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with channel 2 holding 2 words -> immediately out_valid=0000, ch_full=0000, drop_cnt=0, in_ready=1.
- Routing: push 0xA0,0xA1,0xA2,0xA3 with in_sel=0,1,2,3 on consecutive cycles, out_ready=1111 -> each word appears on its slice 1 cycle after acceptance, out_valid pulses one bit per cycle, drop_cnt=0.
- Fill and backpressure: out_ready=0000, push 0x11,0x22,0x33 to sel=1 -> first two accepted, ch_full=0010, third sees in_ready=0, drop_cnt increments each stalled cycle. Raise out_ready[1] -> pops 0x11, 0x22, then 0x33 in order.
- Isolation: channel 1 FULL and stalled, push 0x55 to sel=3 -> accepted immediately (in_ready=1), out_valid[3]=1 next cycle.
- Simultaneous push/pop: channel 0 in ONE with head 0x10, push 0x20 to sel=0 with out_ready[0]=1 -> 0x10 consumed, state stays ONE, head=0x20 next cycle, ch_full[0]=0.
- Saturation: hold a stalled in_valid for 300 cycles -> drop_cnt reaches 255 and stays at 255.
